// File: rtl/io_in.sv
// io_in: synchronized, debounced input pins with edge-capture registers (RISE/FALL, W1C),
// an interrupt mask and a registered level interrupt.
module io_in #(
  parameter int IO_DEPTH  = 32,
  parameter int DB_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [IO_DEPTH-1:0] io_pins_in,
  input  logic [1:0]          io_addr,
  input  logic                io_r_en,
  input  logic                io_w_en,
  input  logic [31:0]         io_data_in,
  output logic [31:0]         io_data_out,
  output logic                io_irq
);
  localparam logic [7:0] CNT_MAX = 8'(DB_CYCLES - 1);
  logic [IO_DEPTH-1:0] sync1_q, sync2_q, deb_q, deb_d, rise_q, rise_d, fall_q, fall_d;
  logic [IO_DEPTH-1:0] mask_q, mask_d, wdata, sel;
  logic [7:0]          cnt_q [IO_DEPTH];
  logic [7:0]          cnt_d [IO_DEPTH];
  logic                irq_d;
  logic                unused_hi;
  assign wdata     = io_data_in[IO_DEPTH-1:0];
  assign unused_hi = ^io_data_in;
  always_comb begin
    for (int i = 0; i < IO_DEPTH; i++) begin
      deb_d[i] = (sync2_q[i] != deb_q[i] && cnt_q[i] == CNT_MAX) ? sync2_q[i] : deb_q[i];
      cnt_d[i] = (sync2_q[i] != deb_q[i] && cnt_q[i] != CNT_MAX) ? cnt_q[i] + 8'd1 : 8'd0;
    end
    // new edges are OR-ed in after the clear so a same-edge set wins
    rise_d = (rise_q & ~((io_w_en && io_addr == 2'd1) ? wdata : '0)) | (deb_d & ~deb_q);
    fall_d = (fall_q & ~((io_w_en && io_addr == 2'd2) ? wdata : '0)) | (~deb_d & deb_q);
    mask_d = (io_w_en && io_addr == 2'd3) ? wdata : mask_q;
    irq_d  = |((rise_q | fall_q) & mask_q);
    sel    = (io_addr == 2'd0) ? deb_q : (io_addr == 2'd1) ? rise_q : (io_addr == 2'd2) ? fall_q : mask_q;
    io_data_out = '0;
    if (io_r_en) io_data_out[IO_DEPTH-1:0] = sel;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q   <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      mask_q  <= '0;
      io_irq  <= 1'b0;
      for (int i = 0; i < IO_DEPTH; i++) cnt_q[i] <= 8'd0;
    end else begin
      sync1_q <= io_pins_in;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      mask_q  <= mask_d;
      io_irq  <= irq_d;
      for (int i = 0; i < IO_DEPTH; i++) cnt_q[i] <= cnt_d[i];
    end
  end
endmodule
